// File: rtl/lite_reg_pkg.sv
// lite_reg_pkg -- shared definitions for the Xillybus-lite register bank.
//   Register byte offsets, CTRL/STATUS bit positions, the address-decode
//   enum and small helpers used by lite_reg_bank.
package lite_reg_pkg;

  localparam logic [7:0] OFS_VERSION   = 8'h00;
  localparam logic [7:0] OFS_CTRL      = 8'h04;
  localparam logic [7:0] OFS_STATUS    = 8'h08;
  localparam logic [7:0] OFS_SCRATCH   = 8'h0C;
  localparam logic [7:0] OFS_FIFO_DATA = 8'h10;
  localparam logic [7:0] OFS_TIMESTAMP = 8'h14;
  localparam logic [7:0] OFS_RSVD6     = 8'h18;
  localparam logic [7:0] OFS_RSVD7     = 8'h1C;

  localparam int unsigned CTRL_IRQ_EN_BIT   = 0;
  localparam int unsigned CTRL_FIFO_CLR_BIT = 1;
  localparam int unsigned CTRL_BYTE_LSB     = 8;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    REG_VERSION   = OFS_VERSION[4:2],
    REG_CTRL      = OFS_CTRL[4:2],
    REG_STATUS    = OFS_STATUS[4:2],
    REG_SCRATCH   = OFS_SCRATCH[4:2],
    REG_FIFO_DATA = OFS_FIFO_DATA[4:2],
    REG_TIMESTAMP = OFS_TIMESTAMP[4:2],
    REG_RSVD6     = OFS_RSVD6[4:2],
    REG_RSVD7     = OFS_RSVD7[4:2]
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    return reg_sel_e'(addr[4:2]);
  endfunction

  // Merge new data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lite_evt_fifo.sv
// lite_evt_fifo -- synchronous event FIFO, first-word-fall-through head.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : empties the FIFO at the next edge, overriding push/pop
//   push/wr_data : write request (ignored when full)
//   pop          : advance head (ignored when empty)
//   rd_data      : current head word (valid when !empty)
//   empty/full   : status flags
//   count        : number of stored words (0..DEPTH)
module lite_evt_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [31:0]                wr_data,
  input  logic                       pop,
  output logic [31:0]                rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (cnt == '0);
  // DEPTH is a power of two, so the count MSB is set only when full.
  assign full    = cnt[AW];
  assign count   = cnt;

endmodule

// File: rtl/lite_reg_bank.sv
// lite_reg_bank -- Xillybus-lite register bank with optional event FIFO.
//   user_clk, user_rst_n : clock, asynchronous active-low reset
//   user_wren/user_wstrb/user_addr/user_wr_data : byte-lane write port
//   user_rden/user_rd_data : read port, data registered one cycle after rden
//   user_irq             : registered level interrupt
//   evt_valid/evt_data/evt_ready : fabric event push interface
//   ctrl_out             : CTRL[15:8]
// Build option: define LITE_REG_BANK_FIFO_EN to include the event FIFO.
module lite_reg_bank
  import lite_reg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq,
  input  logic        evt_valid,
  input  logic [31:0] evt_data,
  output logic        evt_ready,
  output logic [7:0]  ctrl_out
);

  reg_sel_e    sel;
  logic        wr_ctrl;
  logic        wr_scratch;
  logic        irq_en_q;
  logic [7:0]  ctrl_q;
  logic [31:0] scratch_q;
  logic [31:0] ts_q;
  logic [31:0] rd_q;
  logic        irq_q;
  logic [31:0] rd_mux;
  logic [31:0] ctrl_word;
  logic [31:0] status_word;
  logic [31:0] fifo_word;
  logic        irq_cond;
  logic        unused_addr;

  assign sel         = decode_addr(user_addr);
  assign wr_ctrl     = user_wren && (sel == REG_CTRL);
  assign wr_scratch  = user_wren && (sel == REG_SCRATCH);
  assign unused_addr = ^{user_addr[31:5], user_addr[1:0]};

`ifdef LITE_REG_BANK_FIFO_EN
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_status;
  logic          fifo_clr;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic [8:0]    count_ext;
  logic [7:0]    count_sat;
  logic          ovf_q;

  assign wr_status = user_wren && (sel == REG_STATUS);
  assign fifo_clr  = wr_ctrl && user_wstrb[0] && user_wr_data[CTRL_FIFO_CLR_BIT];
  assign fifo_pop  = user_rden && (sel == REG_FIFO_DATA);

  lite_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .clr     (fifo_clr),
    .push    (evt_valid),
    .wr_data (evt_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign evt_ready = !fifo_full;

  // Setting wins over a same-cycle clear so a drop is never lost.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ovf_q <= 1'b0;
    end else if (evt_valid && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (wr_status && user_wstrb[0] && user_wr_data[STAT_OVF_BIT]) begin
      ovf_q <= 1'b0;
    end
  end

  // With FIFO_DEPTH=256 the count reaches 256, which must show as 255.
  assign count_ext = 9'(fifo_count);
  assign count_sat = count_ext[8] ? 8'hFF : count_ext[7:0];

  always_comb begin
    status_word                       = '0;
    status_word[STAT_EMPTY_BIT]       = fifo_empty;
    status_word[STAT_FULL_BIT]        = fifo_full;
    status_word[STAT_OVF_BIT]         = ovf_q;
    status_word[STAT_COUNT_LSB +: 8]  = count_sat;
  end

  assign fifo_word = fifo_empty ? '0 : fifo_head;
  assign irq_cond  = irq_en_q && (!fifo_empty || ovf_q);
`else
  logic unused_evt;

  assign unused_evt  = ^{evt_valid, evt_data};
  assign evt_ready   = 1'b0;
  assign status_word = 32'h0000_0001;
  assign fifo_word   = '0;
  assign irq_cond    = 1'b0;
`endif

  always_comb begin
    ctrl_word                       = '0;
    ctrl_word[CTRL_IRQ_EN_BIT]      = irq_en_q;
    ctrl_word[CTRL_BYTE_LSB +: 8]   = ctrl_q;
  end

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      REG_VERSION:   rd_mux = VERSION;
      REG_CTRL:      rd_mux = ctrl_word;
      REG_STATUS:    rd_mux = status_word;
      REG_SCRATCH:   rd_mux = scratch_q;
      REG_FIFO_DATA: rd_mux = fifo_word;
      REG_TIMESTAMP: rd_mux = ts_q;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      irq_en_q  <= 1'b0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      ts_q      <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      ts_q  <= ts_q + 32'd1;
      irq_q <= irq_cond;
      if (wr_ctrl) begin
        if (user_wstrb[0]) irq_en_q <= user_wr_data[CTRL_IRQ_EN_BIT];
        if (user_wstrb[1]) ctrl_q   <= user_wr_data[CTRL_BYTE_LSB +: 8];
      end
      if (wr_scratch) scratch_q <= apply_wstrb(scratch_q, user_wr_data, user_wstrb);
      if (user_rden)  rd_q      <= rd_mux;
    end
  end

  assign user_rd_data = rd_q;
  assign user_irq     = irq_q;
  assign ctrl_out     = ctrl_q;

endmodule

// File: tb/tb_lite_reg_bank.sv
module tb_lite_reg_bank;

  logic        user_clk;
  logic        user_rst_n;
  logic        user_wren;
  logic [3:0]  user_wstrb;
  logic        user_rden;
  logic [31:0] user_addr;
  logic [31:0] user_wr_data;
  logic [31:0] user_rd_data;
  logic        user_irq;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_ready;
  logic [7:0]  ctrl_out;

  int unsigned n_checks;
  int unsigned n_errors;

  lite_reg_bank #(
    .FIFO_DEPTH (16),
    .VERSION    (32'h0001_0000)
  ) dut (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .user_wren    (user_wren),
    .user_wstrb   (user_wstrb),
    .user_rden    (user_rden),
    .user_addr    (user_addr),
    .user_wr_data (user_wr_data),
    .user_rd_data (user_rd_data),
    .user_irq     (user_irq),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .ctrl_out     (ctrl_out)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge user_clk);
    user_wren    = 1'b1;
    user_addr    = addr;
    user_wr_data = data;
    user_wstrb   = strb;
    @(negedge user_clk);
    user_wren    = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge user_clk);
    user_rden = 1'b1;
    user_addr = addr;
    @(negedge user_clk);
    user_rden = 1'b0;
    data      = user_rd_data;
  endtask

  logic [31:0] rd;
  logic [31:0] t1;
  logic [31:0] t2;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    user_rst_n   = 1'b0;
    user_wren    = 1'b0;
    user_wstrb   = 4'h0;
    user_rden    = 1'b0;
    user_addr    = '0;
    user_wr_data = '0;
    evt_valid    = 1'b0;
    evt_data     = '0;

    repeat (3) @(negedge user_clk);
    check("rst_rd_data", user_rd_data, 32'h0);
    check("rst_irq", {31'h0, user_irq}, 32'h0);
    check("rst_ctrl_out", {24'h0, ctrl_out}, 32'h0);
    user_rst_n = 1'b1;

    reg_read(32'h00, rd); check("version", rd, 32'h0001_0000);
    reg_read(32'h0C, rd); check("scratch_rst", rd, 32'h0);
    reg_read(32'h04, rd); check("ctrl_rst", rd, 32'h0);

    reg_write(32'h0C, 32'hDEAD_BEEF, 4'b0101);
    reg_read(32'h0C, rd); check("scratch_0101", rd, 32'h00AD_00EF);
    reg_write(32'h0C, 32'h1122_3344, 4'b1010);
    reg_read(32'h0C, rd); check("scratch_1010", rd, 32'h11AD_33EF);

    reg_write(32'h1C, 32'hFFFF_FFFF, 4'hF);
    reg_read(32'h1C, rd); check("rsvd_1c", rd, 32'h0);
    reg_read(32'h18, rd); check("rsvd_18", rd, 32'h0);

    // write and read the same register in one cycle: read sees old value
    @(negedge user_clk);
    user_wren = 1'b1; user_rden = 1'b1; user_addr = 32'h0C;
    user_wr_data = 32'h5555_5555; user_wstrb = 4'hF;
    @(negedge user_clk);
    user_wren = 1'b0; user_rden = 1'b0;
    check("wr_rd_same_old", user_rd_data, 32'h11AD_33EF);
    reg_read(32'h0C, rd); check("wr_rd_same_new", rd, 32'h5555_5555);

    reg_write(32'h04, 32'h0000_FF01, 4'b0011);
    reg_read(32'h04, rd); check("ctrl_ff01", rd, 32'h0000_FF01);
    check("ctrl_out_ff", {24'h0, ctrl_out}, 32'h0000_00FF);
    reg_write(32'h04, 32'hFFFF_A500, 4'b0010);
    reg_read(32'h04, rd); check("ctrl_lane1", rd, 32'h0000_A501);
    check("ctrl_out_a5", {24'h0, ctrl_out}, 32'h0000_00A5);
    reg_write(32'h04, 32'h0000_0000, 4'b0011);

    reg_read(32'h14, t1);
    reg_read(32'h14, t2);
    check("ts_delta", t2 - t1, 32'd2);

    @(negedge user_clk);
    force dut.ts_q = 32'hFFFF_FFFD;
    release dut.ts_q;
    reg_read(32'h14, t1); check("ts_pre_wrap", t1, 32'hFFFF_FFFE);
    reg_read(32'h14, t2); check("ts_wrap", t2, 32'h0000_0000);

`ifdef LITE_REG_BANK_FIFO_EN
    reg_read(32'h08, rd); check("status_init", rd, 32'h0000_0001);
    check("ready_init", {31'h0, evt_ready}, 32'h1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge user_clk);
      evt_valid = 1'b1;
      evt_data  = 32'(i);
    end
    @(negedge user_clk);
    check("ready_full", {31'h0, evt_ready}, 32'h0);
    evt_data = 32'd17;
    @(negedge user_clk);
    evt_valid = 1'b0;
    reg_read(32'h08, rd); check("status_full_ovf", rd, 32'h0000_1006);
    for (int i = 1; i <= 16; i++) begin
      reg_read(32'h10, rd);
      check($sformatf("pop_%0d", i), rd, 32'(i));
    end
    reg_read(32'h08, rd); check("status_empty_ovf", rd, 32'h0000_0005);
    reg_read(32'h10, rd); check("pop_empty", rd, 32'h0);
    reg_read(32'h08, rd); check("status_after_empty_pop", rd, 32'h0000_0005);
    reg_write(32'h08, 32'h0000_0004, 4'b1110);
    reg_read(32'h08, rd); check("w1c_no_strb", rd, 32'h0000_0005);
    reg_write(32'h08, 32'h0000_0004, 4'b0001);
    reg_read(32'h08, rd); check("w1c_ovf", rd, 32'h0000_0001);

    reg_write(32'h04, 32'h0000_0001, 4'b0001);
    @(negedge user_clk);
    evt_valid = 1'b1; evt_data = 32'h0000_CAFE;
    @(negedge user_clk);
    evt_valid = 1'b0;
    @(negedge user_clk);
    check("irq_set", {31'h0, user_irq}, 32'h1);
    reg_read(32'h10, rd); check("irq_pop", rd, 32'h0000_CAFE);
    reg_write(32'h08, 32'h0000_0004, 4'b0001);
    check("irq_clear", {31'h0, user_irq}, 32'h0);

    for (int i = 1; i <= 3; i++) begin
      @(negedge user_clk);
      evt_valid = 1'b1;
      evt_data  = 32'(i * 16);
    end
    @(negedge user_clk);
    evt_data = 32'h40; user_rden = 1'b1; user_addr = 32'h10;
    @(negedge user_clk);
    evt_valid = 1'b0; user_rden = 1'b0;
    check("pushpop_data", user_rd_data, 32'h10);
    reg_read(32'h08, rd); check("pushpop_count", rd, 32'h0000_0300);

    @(negedge user_clk);
    user_wren = 1'b1; user_addr = 32'h04; user_wr_data = 32'h0000_0003; user_wstrb = 4'b0001;
    evt_valid = 1'b1; evt_data = 32'h99;
    @(negedge user_clk);
    user_wren = 1'b0; evt_valid = 1'b0;
    reg_read(32'h08, rd); check("clr_status", rd, 32'h0000_0001);
    reg_read(32'h10, rd); check("clr_fifo_data", rd, 32'h0);
    reg_read(32'h04, rd); check("clr_reads_0", rd, 32'h0000_0001);
    check("clr_irq", {31'h0, user_irq}, 32'h0);
`else
    reg_write(32'h04, 32'h0000_0001, 4'b0001);
    @(negedge user_clk);
    evt_valid = 1'b1; evt_data = 32'h77;
    check("nofifo_ready", {31'h0, evt_ready}, 32'h0);
    @(negedge user_clk);
    evt_valid = 1'b0;
    reg_read(32'h10, rd); check("nofifo_data", rd, 32'h0);
    reg_read(32'h08, rd); check("nofifo_status", rd, 32'h0000_0001);
    @(negedge user_clk);
    check("nofifo_irq", {31'h0, user_irq}, 32'h0);
`endif

    reg_write(32'h04, 32'h0000_7701, 4'b0011);
`ifdef LITE_REG_BANK_FIFO_EN
    @(negedge user_clk);
    evt_valid = 1'b1; evt_data = 32'h1234;
    @(negedge user_clk);
    evt_valid = 1'b0;
    @(negedge user_clk);
    check("pre_rst_irq", {31'h0, user_irq}, 32'h1);
`endif
    reg_read(32'h00, rd); check("pre_rst_rd", rd, 32'h0001_0000);
    @(negedge user_clk);
    evt_valid = 1'b1; evt_data = 32'h5;
    #2 user_rst_n = 1'b0;
    #1;
    check("async_rst_rd", user_rd_data, 32'h0);
    check("async_rst_irq", {31'h0, user_irq}, 32'h0);
    check("async_rst_ctrl_out", {24'h0, ctrl_out}, 32'h0);
    @(negedge user_clk);
    evt_valid = 1'b0;
    @(negedge user_clk);
    user_rst_n = 1'b1;
    reg_read(32'h08, rd); check("post_rst_status", rd, 32'h0000_0001);
    reg_read(32'h04, rd); check("post_rst_ctrl", rd, 32'h0);
    reg_read(32'h0C, rd); check("post_rst_scratch", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lite_reg_bank.md
LITE_REG_BANK -- requirements
Module: lite_reg_bank

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, event FIFO depth (power of two, 4..256).
REQ-002 SHALL have parameter VERSION, default 32'h0001_0000, value returned by the VERSION register.
REQ-003 SHALL have port user_clk, in, 1, the single clock (Xillybus-lite user clock).
REQ-004 SHALL have port user_rst_n, in, 1. Reset is asynchronous and active-low.
REQ-005 SHALL have port user_wren, in, 1, write strobe, one cycle per write.
REQ-006 SHALL have port user_wstrb, in, 4, byte enables for the write.
REQ-007 SHALL have port user_rden, in, 1, read strobe, one cycle per read.
REQ-008 SHALL have port user_addr, in, 32, byte address; only [4:2] decoded.
REQ-009 SHALL have port user_wr_data, in, 32, write data.
REQ-010 SHALL have port user_rd_data, out, 32, read data.
REQ-011 SHALL have port user_irq, out, 1, level interrupt to the PS.
REQ-012 SHALL have port evt_valid, in, 1, fabric event push request.
REQ-013 SHALL have port evt_data, in, 32, event word.
REQ-014 SHALL have port evt_ready, out, 1, equal to !fifo_full (combinational).
REQ-015 SHALL have port ctrl_out, out, 8, equal to CTRL[15:8].

Function
REQ-016 SHALL use this map: 0x00 VERSION RO; 0x04 CTRL RW; 0x08 STATUS; 0x0C SCRATCH RW; 0x10 FIFO_DATA RO; 0x14 TIMESTAMP RO; 0x18/0x1C read 0, writes ignored.
REQ-017 SHALL register user_rd_data so it is valid exactly one user_clk after user_rden, and hold it until the next read.
REQ-018 SHALL apply writes per byte lane where user_wstrb[n]=1; lanes with strobe 0 are unchanged.
REQ-019 CTRL: bit0 irq_en, bit1 fifo_clr (write-1 pulse, reads 0), bits[15:8] ctrl, other bits read 0.
REQ-020 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky; write-1-clears, needs wstrb[0]), bits[15:8] fill count (saturates at 255), other bits 0.
REQ-021 A push SHALL occur when evt_valid && evt_ready.
REQ-022 evt_valid while full SHALL drop the word and set overflow, even if a pop occurs in the same cycle.
REQ-023 A read of FIFO_DATA SHALL return the head word and pop it.
REQ-024 A FIFO_DATA read while empty SHALL return 0 and leave the FIFO state unchanged.
REQ-025 A simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-026 fifo_clr SHALL empty the FIFO in the next cycle, and wins over a same-cycle push or pop; overflow is unaffected.
REQ-027 TIMESTAMP SHALL be a 32-bit free-running counter, +1 per cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-028 user_irq SHALL be registered: irq_en && (!empty || overflow).
REQ-029 Simultaneous user_wren and user_rden SHALL both be served, each decoded from the same user_addr.

Reset
REQ-030 On user_rst_n low, asynchronously: user_rd_data=0, user_irq=0, CTRL=0, SCRATCH=0, TIMESTAMP=0, FIFO empty, overflow=0, ctrl_out=0.
REQ-031 A push or read in flight at reset SHALL be discarded; reset deassertion is synchronised by the instantiating level.

Configuration
REQ-032 With LITE_REG_BANK_FIFO_EN defined, the event FIFO, overflow flag, and REQ-021..026 SHALL be present.
REQ-033 Without it: evt_ready=0, FIFO_DATA reads 0, STATUS reads 32'h1 (empty), and user_irq is always 0.

Structure
REQ-034 The shared package lite_reg_pkg SHALL hold the register offset constants, CTRL/STATUS bit-index constants, and the address-decode enum type.
REQ-035 The FIFO SHALL be the sub-module lite_evt_fifo (sync, first-word-fall-through head, count output); decode and registers stay in lite_reg_bank.

Verification
REQ-036 Reset, then read 0x00 -> 32'h0001_0000 one cycle after rden; read 0x0C -> 0.
REQ-037 Write 0x0C with 32'hDEAD_BEEF, wstrb=4'b0101, from 0 -> SCRATCH reads 32'h00AD_00EF.
REQ-038 Push 16 words 1..16, then a 17th -> evt_ready=0 after 16; STATUS reads 32'h0000_1006; 16 FIFO_DATA reads return 1..16; then STATUS reads 32'h0000_0005.
REQ-039 CTRL=1, push 1 word -> user_irq=1 within 2 cycles; pop it and W1C overflow -> user_irq=0.
REQ-040 Push and pop in the same cycle with count 3 -> count stays 3. fifo_clr with a concurrent push -> count 0, empty=1.
REQ-041 Force TIMESTAMP to 0xFFFF_FFFE via reset-release timing and read twice, 2 cycles apart -> the wrap to 0 is observed. Assert user_rst_n mid-push -> all outputs 0 asynchronously.
